// File: rtl/arm_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package arm_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      FS_RUN,
      FS_HALT
   } fetch_state_t;

endpackage

// File: rtl/arm_fetch_unit_if.sv
// Decoder-side and memory-side signals of the fetch unit.
// The fetch unit uses the master modport; the decoder and memory use the slave one.
interface arm_fetch_unit_if;
   import arm_fetch_pkg::*;

   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        halted;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output inst_valid, inst, inst_pc, imem_req, imem_addr,
      input  inst_ready, redirect_en, redirect_pc, halted, imem_gnt, imem_rvalid, imem_rdata
   );

   modport slave (
      input  inst_valid, inst, inst_pc, imem_req, imem_addr,
      output inst_ready, redirect_en, redirect_pc, halted, imem_gnt, imem_rvalid, imem_rdata
   );

endinterface

// File: rtl/arm_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {pc, inst} words with a registered head.
// Flush has priority over push and pop.
module arm_fetch_fifo
   import arm_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             push_i,
   input  fetch_entry_t     push_data_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output fetch_entry_t     head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   fetch_entry_t    mem_q [DEPTH];
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop_i & ~empty_o;
      // A full queue can still accept a push when the head leaves the same cycle
      do_push  = push_i & (~full_o | do_pop);
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction-fetch front end: credit-limited requests to a multi-cycle memory,
// in-order response buffering, branch redirect with stale-response dropping, sticky halt.
module arm_fetch_unit
   import arm_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH    = 2
) (
   input logic               clk,
   input logic               rst_b,
   arm_fetch_unit_if.master  bus
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned SumW = CntW + 1;

   fetch_state_t    state_q, state_d;
   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     resp_pc_q, resp_pc_d;
   logic [CntW-1:0] in_flight_q, in_flight_d;
   logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
   logic            bubble_q, bubble_d;

   logic            running, halt_now, redirect, credit_ok;
   logic            req, granted, dropping, push, pop;
   logic            fifo_full, fifo_empty;
   logic [CntW-1:0] q_count;
   fetch_entry_t    head;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      resp_pc_d   = resp_pc_q;
      drop_cnt_d  = drop_cnt_q;
      bubble_d    = 1'b0;

      running   = (state_q == FS_RUN);
      halt_now  = running & bus.halted;
      redirect  = running & bus.redirect_en & ~bus.halted;
      credit_ok = ({1'b0, in_flight_q} + {1'b0, q_count}) < SumW'(DEPTH);
      req       = rst_b & running & ~bubble_q & credit_ok;
      granted   = req & bus.imem_gnt;
      dropping  = (drop_cnt_q != '0);
      push      = bus.imem_rvalid & ~dropping & running;
      pop       = running & ~fifo_empty & bus.inst_ready & ~redirect;

      if (granted) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
      in_flight_d = in_flight_q + CntW'(granted)
                  - CntW'(bus.imem_rvalid && (in_flight_q != '0));
      if (push) begin
         resp_pc_d = resp_pc_q + 32'd4;
      end
      if (bus.imem_rvalid && dropping) begin
         drop_cnt_d = drop_cnt_q - 1'b1;
      end

      if (halt_now) begin
         state_d = FS_HALT;
      end

      // Everything still outstanding after this cycle belongs to the old path
      if (redirect) begin
         fetch_pc_d = bus.redirect_pc & ~32'h3;
         resp_pc_d  = bus.redirect_pc & ~32'h3;
         drop_cnt_d = in_flight_d;
         bubble_d   = req & ~bus.imem_gnt;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q     <= FS_RUN;
         fetch_pc_q  <= RESET_PC;
         resp_pc_q   <= RESET_PC;
         in_flight_q <= '0;
         drop_cnt_q  <= '0;
         bubble_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         resp_pc_q   <= resp_pc_d;
         in_flight_q <= in_flight_d;
         drop_cnt_q  <= drop_cnt_d;
         bubble_q    <= bubble_d;
         if (!redirect) begin
            assert (!(push && fifo_full && !pop)) else $error("fetch queue overflow");
         end
      end
   end

   arm_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_b       (rst_b),
      .push_i      (push),
      .push_data_i ('{pc: resp_pc_q, inst: bus.imem_rdata}),
      .pop_i       (pop),
      .flush_i     (redirect),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (q_count)
   );

   assign bus.imem_req   = req;
   assign bus.imem_addr  = fetch_pc_q;
   assign bus.inst_valid = running & ~fifo_empty;
   assign bus.inst       = head.inst;
   assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Bench for arm_fetch_unit: memory model plus a program-order reference model
// (expected fetch stream per path epoch) checked every cycle.
module tb_arm_fetch_unit;
   import arm_fetch_pkg::*;

   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   arm_fetch_unit_if bus ();

   arm_fetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          due;
      int          epoch;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] gnt_log[$];
   logic [31:0] cons_log[$];

   int          checks = 0;
   int          errors = 0;
   int          cyc, buf_m, epoch, last_due, first_valid_cyc;
   logic [31:0] issue_pc, cons_pc, redir_tgt;
   bit          halted_m, bubble_m;
   int          gnt_mode, rdy_mode, lat_lo, lat_hi;
   bit          redir_req, halt_req, dead, redir_arm, redir_fired;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.inst_ready  = 1'b0;
      bus.redirect_en = 1'b0;
      bus.redirect_pc = '0;
      bus.halted      = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
   endtask

   // Reset spans two edges; the first run cycle after it is numbered 1.
   task automatic do_reset();
      @(negedge clk);
      rst_b = 1'b0;
      drive_idle();
      @(posedge clk);
      @(negedge clk);
      chk("reset imem_req", bus.imem_req, 0);
      chk("reset inst_valid", bus.inst_valid, 0);
      chk("reset inst", bus.inst, 0);
      chk("reset inst_pc", bus.inst_pc, 0);
      @(posedge clk);
      #1 rst_b = 1'b1;
      pend.delete();
      gnt_log.delete();
      cons_log.delete();
      cyc = 1;
      buf_m = 0;
      epoch++;
      last_due = 0;
      first_valid_cyc = -1;
      issue_pc = RST_PC;
      cons_pc = RST_PC;
      halted_m = 1'b0;
      bubble_m = 1'b0;
      redir_req = 1'b0;
      halt_req = 1'b0;
      redir_arm = 1'b0;
      redir_fired = 1'b0;
   endtask

   task automatic step();
      bit exp_req, exp_valid, gnt, rdy, rv, redir, redir_eff;
      int d;
      pend_t h;
      @(negedge clk);
      exp_req   = !halted_m && !bubble_m && (pend.size() + buf_m < DEPTH);
      exp_valid = !halted_m && (buf_m > 0);
      chk("imem_req", bus.imem_req, exp_req);
      chk("inst_valid", bus.inst_valid, exp_valid);
      chk("q_count", dut.q_count, 32'(buf_m));
      if (exp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

      gnt   = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 1) == 1);
      rdy   = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 3) != 0);
      rv    = (pend.size() > 0) && (pend[0].due <= cyc);
      redir = redir_req || (redir_arm && rv && exp_valid && rdy);
      if (redir_arm && redir) begin
         redir_arm   = 1'b0;
         redir_fired = 1'b1;
      end
      redir_req = 1'b0;

      bus.imem_gnt    = gnt;
      bus.inst_ready  = rdy;
      bus.halted      = halt_req;
      bus.redirect_en = redir;
      bus.redirect_pc = redir ? redir_tgt : $urandom;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rv ? pend[0].data : $urandom;

      redir_eff = redir && !halt_req && !halted_m;
      if (rv) begin
         h = pend.pop_front();
         if (h.epoch == epoch && !halted_m && !redir_eff) buf_m++;
      end
      if (exp_valid && rdy && !redir_eff) begin
         chk("inst_pc", bus.inst_pc, cons_pc);
         chk("inst", bus.inst, word_of(cons_pc));
         cons_log.push_back(bus.inst_pc);
         cons_pc += 32'd4;
         buf_m--;
      end
      if (exp_req && gnt) begin
         chk("imem_addr", bus.imem_addr, issue_pc);
         d = cyc + int'($urandom_range(lat_lo, lat_hi));
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         pend.push_back('{addr: issue_pc, data: dead ? 32'hDEAD_BEEF : word_of(issue_pc),
                          due: d, epoch: epoch});
         gnt_log.push_back(issue_pc);
         issue_pc += 32'd4;
      end
      bubble_m = redir_eff && exp_req && !gnt;
      if (redir_eff) begin
         epoch++;
         buf_m    = 0;
         issue_pc = redir_tgt & ~32'h3;
         cons_pc  = redir_tgt & ~32'h3;
      end
      if (halt_req) halted_m = 1'b1;
      @(posedge clk);
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int nb, cb, old_cnt;
      rst_b = 1'b0;
      drive_idle();
      epoch = 0;
      dead = 1'b0;

      // Streaming fetch, single-cycle memory
      gnt_mode = 1; rdy_mode = 1; lat_lo = 1; lat_hi = 1;
      do_reset();
      run(10);
      chk("t1 first valid cycle", 32'(first_valid_cyc), 3);
      chk("t1 pc0", cons_log[0], 32'h0040_0000);
      chk("t1 pc1", cons_log[1], 32'h0040_0004);
      chk("t1 pc2", cons_log[2], 32'h0040_0008);

      // Decoder stalled: credits cap the outstanding work at DEPTH
      rdy_mode = 0;
      do_reset();
      run(10);
      #2;
      chk("t2 grants", 32'(gnt_log.size()), 2);
      chk("t2 imem_req", bus.imem_req, 0);
      chk("t2 q_count", dut.q_count, 2);

      // Drain in order
      rdy_mode = 1;
      run(10);
      chk("t3 drain0", cons_log[0], 32'h0040_0000);
      chk("t3 drain1", cons_log[1], 32'h0040_0004);
      chk("t3 drained", 32'(cons_log.size() >= 4), 1);

      // Redirect with two slow requests outstanding
      rdy_mode = 0; lat_lo = 6; lat_hi = 6;
      do_reset();
      dead = 1'b1;
      run(2);
      dead = 1'b0;
      redir_tgt = 32'h0040_0103;
      redir_req = 1'b1;
      step();
      nb = gnt_log.size();
      cb = cons_log.size();
      rdy_mode = 1; lat_lo = 1; lat_hi = 1;
      run(15);
      chk("t4 in flight at redirect", 32'(nb), 2);
      chk("t4 new addr", (gnt_log.size() > nb) ? gnt_log[nb] : 32'hFFFF_FFFF, 32'h0040_0100);
      chk("t4 new pc", (cons_log.size() > cb) ? cons_log[cb] : 32'hFFFF_FFFF, 32'h0040_0100);

      // Redirect coinciding with rvalid and a pop
      gnt_mode = 2; lat_lo = 1; lat_hi = 2;
      redir_tgt = 32'h0000_2000;
      redir_arm = 1'b1;
      for (int i = 0; i < 40 && !redir_fired; i++) step();
      chk("t5 fired", 32'(redir_fired), 1);
      #2;
      old_cnt = 0;
      foreach (pend[i]) if (pend[i].epoch != epoch) old_cnt++;
      chk("t5 inst_valid", bus.inst_valid, 0);
      chk("t5 drop_cnt", dut.drop_cnt_q, 32'(old_cnt));
      run(10);

      // Halt beats redirect; late response ignored
      gnt_mode = 1; rdy_mode = 1; lat_lo = 5; lat_hi = 5;
      do_reset();
      step();
      gnt_mode = 0;
      step();
      halt_req = 1'b1; redir_req = 1'b1; redir_tgt = 32'h0050_0000;
      step();
      halt_req = 1'b0; gnt_mode = 1;
      run(10);
      chk("t6 state", 32'(dut.state_q), 32'(FS_HALT));
      chk("t6 grants", 32'(gnt_log.size()), 1);

      // Reset out of HALT with a full queue
      rdy_mode = 0; lat_lo = 1; lat_hi = 1;
      do_reset();
      run(6);
      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      run(3);
      chk("t7 q_count in halt", dut.q_count, 2);
      rdy_mode = 1;
      do_reset();
      run(8);
      chk("t7 refetch addr", gnt_log[0], RST_PC);
      chk("t7 refetch pc", cons_log[0], RST_PC);

      // Address wrap, then randomized traffic with occasional redirects
      gnt_mode = 2; rdy_mode = 2; lat_lo = 1; lat_hi = 3;
      redir_tgt = 32'hFFFF_FFF6;
      redir_req = 1'b1;
      run(30);
      chk("wrap reached zero", 32'(cons_log[cons_log.size() - 1] < 32'h100), 1);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            redir_req = 1'b1;
            redir_tgt = $urandom;
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
